ring_freq_counter: RTL and testbench
====================================

RING_FREQ_COUNTER -- requirements
Module: ring_freq_counter

Interface
REQ-001 Parameter CNT_W, default 16: result counter width in bits.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser depth for ring_div, minimum 2.
REQ-003 clk  input  1  single system clock; all state is clocked on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ring_div  input  1  tapped_ring output after the upstream divider; asynchronous to clk; high and low phases each guaranteed longer than one clk period.
REQ-006 ena  input  1  block enable; low aborts any measurement.
REQ-007 start  input  1  single-cycle request to begin a measurement.
REQ-008 win_sel  input  2  gate window select: 0 = 1024, 1 = 2048, 2 = 4096, 3 = 8192 clk cycles.
REQ-009 count  output  CNT_W  last completed result, in ring_div rising edges per window.
REQ-010 valid  output  1  one-cycle pulse when count updates.
REQ-011 busy  output  1  high while a measurement is in progress.
REQ-012 overflow  output  1  high if the last result saturated.

Function
REQ-013 ring_div shall pass through SYNC_STAGES flops and then a rising-edge detector, giving a one-cycle pulse per rising edge. Pulse latency is SYNC_STAGES+1 clk cycles.
REQ-014 FSM states: IDLE, ARM, MEASURE, DONE.
REQ-015 IDLE -> ARM when start=1 and ena=1. win_sel is sampled into a register on this same cycle and is ignored afterwards until the next start.
REQ-016 ARM shall last exactly one cycle. It clears the edge accumulator and loads the window counter with window-1, then moves to MEASURE.
REQ-017 MEASURE shall last exactly the selected window length in clk cycles. Each cycle, it adds 1 to the accumulator if an edge pulse is present, and decrements the window counter.
REQ-018 MEASURE -> DONE on the cycle the window counter reads 0. The edge pulse on that final cycle is counted.
REQ-019 DONE shall last one cycle. It latches the accumulator into count, sets overflow, and asserts valid, then returns to IDLE.
REQ-020 The accumulator shall saturate at 2^CNT_W-1 and shall not wrap. When saturation occurs, overflow for that result shall be 1; otherwise it shall be 0.
REQ-021 busy shall be 1 in ARM, MEASURE and DONE, and 0 in IDLE.
REQ-022 start while busy=1 shall be ignored, with no queuing.
REQ-023 ena=0 in any non-IDLE state shall force IDLE on the next cycle. In that case, valid is not asserted and count and overflow keep their previous values.
REQ-024 start in the same cycle that DONE returns to IDLE shall be ignored; a new start is needed in IDLE.
REQ-025 count and overflow shall hold their values between measurements.

Reset
REQ-026 rst_n=0 shall, asynchronously, set the state to IDLE and clear the synchroniser flops, edge register, accumulator, window counter and registered win_sel.
REQ-027 rst_n=0 shall also set all outputs to 0: count, valid, busy and overflow.
REQ-028 Reset asserted mid-measurement shall discard that measurement. No valid shall be produced after reset is released.
REQ-029 After rst_n deasserts, the first edge pulse shall not be generated until the synchroniser has filled; a ring_div level that is already high shall not produce a spurious edge.

Structure
REQ-030 A shared package shall hold the FSM state enum and the window-length constant table indexed by win_sel.
REQ-031 The package shall also hold the window counter width, which is 13 bits.
REQ-032 One sub-module, sync_edge, shall implement the synchroniser plus rising-edge detector, parameterised by SYNC_STAGES.
REQ-033 The implementation shall not use ring_div as a clock anywhere.

Verification
REQ-034 Scenario 1: ring_div period 8 clk (4 high/4 low), win_sel=0, start -> valid after 1024+2 cycles; count=128 (±1); overflow=0.
REQ-035 Scenario 2: ring_div period 4 clk, win_sel=3 -> count=2048 (±1); busy high for exactly 8194 cycles.
REQ-036 Scenario 3: ring_div held constant at 1, win_sel=1 -> count=0; no edge pulse at reset release.
REQ-037 Scenario 4: CNT_W=8, ring_div period 3 clk, win_sel=0 -> count=255, overflow=1.
REQ-038 Scenario 5: start at cycle 0, extra starts at cycles 10 and 500, then ena=0 at cycle 600 -> IDLE at cycle 601, no valid, count unchanged.
REQ-039 Scenario 6: rst_n pulsed low mid-MEASURE -> all outputs 0 immediately; no valid afterwards; a new start gives a correct result.

Source files
------------

// File: rtl/ring_freq_counter_pkg.sv
// Shared FSM encoding and gate-window table for the ring frequency counter.
// Window lengths are in clk cycles, indexed by win_sel.
package ring_freq_counter_pkg;

  localparam int WIN_W = 13;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [3:0][WIN_W:0] WIN_LEN = {14'd8192, 14'd4096, 14'd2048, 14'd1024};

  // Window counter preload: it counts down to 0, so the last MEASURE cycle is the one reading 0.
  function automatic logic [WIN_W-1:0] win_load(input logic [1:0] sel);
    logic [WIN_W:0] last;
    last = WIN_LEN[sel] - (WIN_W + 1)'(1);
    return last[WIN_W-1:0];
  endfunction

endpackage

// File: rtl/ring_freq_counter_if.sv
// Control and result signals of the ring frequency counter.
// master drives ring_div/ena/start/win_sel; slave (the counter) returns the result.
interface ring_freq_counter_if #(
  parameter int CNT_W = 16
);
  logic             ring_div;
  logic             ena;
  logic             start;
  logic [1:0]       win_sel;
  logic [CNT_W-1:0] count;
  logic             valid;
  logic             busy;
  logic             overflow;

  modport master (
    output ring_div, ena, start, win_sel,
    input  count, valid, busy, overflow
  );

  modport slave (
    input  ring_div, ena, start, win_sel,
    output count, valid, busy, overflow
  );
endinterface

// File: rtl/sync_edge.sv
// Synchroniser plus rising-edge detector; one-cycle pulse SYNC_STAGES+1 cycles after a rise.
// No backpressure; pulses are suppressed until the chain has filled after reset.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ring_div_i,
  output logic edge_o
);

  localparam int FILL   = SYNC_STAGES + 1;
  localparam int FILL_W = $clog2(FILL + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   edge_q;
  logic [FILL_W-1:0]      fill_q;
  logic                   filled;

  // prev_q only holds a real sample once the chain is full, so a level already high at
  // reset release must not look like a rising edge.
  assign filled = (fill_q == FILL_W'(FILL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ring_div_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      edge_q <= filled & sync_q[SYNC_STAGES-1] & ~prev_q;
      if (!filled) begin
        fill_q <= fill_q + FILL_W'(1);
      end
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/ring_freq_counter.sv
// Counts ring_div rising edges over a 1024..8192-cycle gate; result valid window+2 cycles after start.
// No backpressure: valid is a one-cycle pulse, count/overflow hold until the next result.
module ring_freq_counter
  import ring_freq_counter_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                rst_n,
  ring_freq_counter_if.slave bus
);

  state_t             state_q, state_d;
  logic [1:0]         win_sel_q, win_sel_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic               sat_q, sat_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               edge_pulse;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .ring_div_i(bus.ring_div),
    .edge_o    (edge_pulse)
  );

  always_comb begin
    state_d   = state_q;
    win_sel_d = win_sel_q;
    win_cnt_d = win_cnt_q;
    acc_d     = acc_q;
    sat_d     = sat_q;
    count_d   = count_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && bus.ena) begin
          state_d   = ST_ARM;
          win_sel_d = bus.win_sel;
        end
      end
      ST_ARM: begin
        acc_d     = '0;
        sat_d     = 1'b0;
        win_cnt_d = win_load(win_sel_q);
        state_d   = ST_MEASURE;
      end
      ST_MEASURE: begin
        // overflow means an edge was actually dropped, not merely that the ceiling was reached
        if (edge_pulse) begin
          if (&acc_q) begin
            sat_d = 1'b1;
          end else begin
            acc_d = acc_q + CNT_W'(1);
          end
        end
        win_cnt_d = win_cnt_q - WIN_W'(1);
        if (win_cnt_q == '0) begin
          state_d = ST_DONE;
          count_d = acc_d;
          ovf_d   = sat_d;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_q != ST_IDLE && !bus.ena) begin
      state_d = ST_IDLE;
      count_d = count_q;
      ovf_d   = ovf_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      win_sel_q <= '0;
      win_cnt_q <= '0;
      acc_q     <= '0;
      sat_q     <= 1'b0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_sel_q <= win_sel_d;
      win_cnt_q <= win_cnt_d;
      acc_q     <= acc_d;
      sat_q     <= sat_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;
  assign bus.valid    = (state_q == ST_DONE);
  assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ring_freq_counter.sv
// Directed bench: a 16-bit and an 8-bit counter share all stimulus; ring_div comes from a free-running generator.
module tb_ring_freq_counter;

  logic       clk;
  logic       rst_n;
  logic       ring_div;
  logic       ena;
  logic       start;
  logic [1:0] win_sel;

  int ring_half = 0;
  logic ring_hold = 1'b0;

  int total = 0;
  int bad   = 0;

  ring_freq_counter_if #(.CNT_W(16)) if16 ();
  ring_freq_counter_if #(.CNT_W(8))  if8 ();

  assign if16.ring_div = ring_div;
  assign if16.ena      = ena;
  assign if16.start    = start;
  assign if16.win_sel  = win_sel;
  assign if8.ring_div  = ring_div;
  assign if8.ena       = ena;
  assign if8.start     = start;
  assign if8.win_sel   = win_sel;

  ring_freq_counter #(.CNT_W(16), .SYNC_STAGES(2)) u_dut16 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if16)
  );

  ring_freq_counter #(.CNT_W(8), .SYNC_STAGES(2)) u_dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ring_half is half the ring_div period in ns; 0 holds ring_div at ring_hold.
  initial begin
    ring_div = 1'b0;
    forever begin
      if (ring_half == 0) begin
        ring_div = ring_hold;
        #1;
      end else begin
        #(ring_half);
        ring_div = ~ring_div;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_meas(input logic [1:0] ws, input int extra,
                          output int lat, output int busy_cyc, output int vcnt);
    int n;
    @(negedge clk);
    win_sel = ws;
    ena     = 1'b1;
    start   = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    n        = 1;
    lat      = 0;
    busy_cyc = 0;
    vcnt     = 0;
    while (if16.busy && n < 9000) begin
      busy_cyc++;
      if (if16.valid) begin
        vcnt++;
        if (lat == 0) lat = n;
      end
      start = (n == extra);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    total++;
    if (n >= 9000) begin
      bad++;
      $display("FAIL meas_timeout: busy still %0b after %0d cycles, required to end", if16.busy, n);
    end
  endtask

  task automatic test_reset;
    ena       = 1'b0;
    start     = 1'b0;
    win_sel   = 2'd0;
    ring_half = 0;
    ring_hold = 1'b0;
    rst_n     = 1'b1;
    #2 rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (if16.count !== 16'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", if16.count); end
    total++; if (if16.valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", if16.valid); end
    total++; if (if16.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b want 0", if16.busy); end
    total++; if (if16.overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow: got %0b want 0", if16.overflow); end
    total++; if (if8.count !== 8'd0) begin bad++; $display("FAIL rst_count8: got %0d want 0", if8.count); end
  endtask

  // ring_div already high when reset releases must give no edge.
  task automatic test_no_spurious;
    int lat, bc, vc;
    ring_hold = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_meas(2'd1, -1, lat, bc, vc);
    total++; if (lat !== 2050) begin bad++; $display("FAIL s3_latency: got %0d want 2050", lat); end
    total++; if (if16.count !== 16'd0) begin bad++; $display("FAIL s3_count: got %0d want 0", if16.count); end
    total++; if (if16.overflow !== 1'b0) begin bad++; $display("FAIL s3_overflow: got %0b want 0", if16.overflow); end
    total++; if (vc !== 1) begin bad++; $display("FAIL s3_valid_cycles: got %0d want 1 (busy %0d)", vc, bc); end
  endtask

  task automatic test_win1024;
    int lat, bc, vc, c16;
    ring_half = 40;
    repeat (20) @(negedge clk);
    run_meas(2'd0, -1, lat, bc, vc);
    c16 = int'(if16.count);
    total++; if (lat !== 1026) begin bad++; $display("FAIL s1_latency: got %0d want 1026", lat); end
    total++; if (c16 < 127 || c16 > 129) begin bad++; $display("FAIL s1_count: got %0d want 127..129", c16); end
    total++; if (if16.overflow !== 1'b0) begin bad++; $display("FAIL s1_overflow: got %0b want 0", if16.overflow); end
    total++; if (vc !== 1) begin bad++; $display("FAIL s1_valid_cycles: got %0d want 1", vc); end
    total++; if (bc !== 1026) begin bad++; $display("FAIL s1_busy_cycles: got %0d want 1026", bc); end
    total++; if (if8.count !== if16.count[7:0] || if8.overflow !== 1'b0) begin
      bad++; $display("FAIL s1_cnt8: got %0d ovf %0b want %0d ovf 0", if8.count, if8.overflow, c16);
    end
  endtask

  task automatic test_win8192;
    int lat, bc, vc, c16;
    ring_half = 20;
    repeat (20) @(negedge clk);
    run_meas(2'd3, -1, lat, bc, vc);
    c16 = int'(if16.count);
    total++; if (c16 < 2047 || c16 > 2049) begin bad++; $display("FAIL s2_count: got %0d want 2047..2049", c16); end
    total++; if (bc !== 8194) begin bad++; $display("FAIL s2_busy_cycles: got %0d want 8194", bc); end
    total++; if (lat !== 8194 || vc !== 1) begin bad++; $display("FAIL s2_valid: latency %0d x%0d want 8194 x1", lat, vc); end
  endtask

  task automatic test_saturate;
    int lat, bc, vc, c16;
    ring_half = 15;
    repeat (20) @(negedge clk);
    run_meas(2'd0, -1, lat, bc, vc);
    c16 = int'(if16.count);
    total++; if (if8.count !== 8'd255) begin bad++; $display("FAIL s4_count8: got %0d want 255", if8.count); end
    total++; if (if8.overflow !== 1'b1) begin bad++; $display("FAIL s4_overflow8: got %0b want 1", if8.overflow); end
    total++; if (c16 < 340 || c16 > 342) begin bad++; $display("FAIL s4_count16: got %0d want 340..342", c16); end
    total++; if (if16.overflow !== 1'b0 || lat !== 1026) begin
      bad++; $display("FAIL s4_ovf16_lat: got ovf %0b lat %0d want 0 1026 (busy %0d valid %0d)", if16.overflow, lat, bc, vc);
    end
  endtask

  // Start at 0, ignored starts at 10 and 500, ena low from 600; nothing may be queued.
  task automatic test_abort;
    int vseen, busy_after, c16;
    logic busy600, busy601;
    vseen = 0; busy_after = 0; busy600 = 1'b0; busy601 = 1'b1;
    ring_half = 40;
    @(negedge clk);
    for (int c = 0; c <= 1700; c++) begin
      start   = (c == 0 || c == 10 || c == 500);
      win_sel = (c == 0) ? 2'd3 : 2'd0;
      ena     = (c < 600) || (c > 602);
      @(negedge clk);
      if (if16.valid || if8.valid) vseen++;
      if (c + 1 == 600) busy600 = if16.busy;
      if (c + 1 == 601) busy601 = if16.busy;
      if (c + 1 > 601 && if16.busy) busy_after++;
    end
    start = 1'b0;
    ena   = 1'b1;
    c16   = int'(if16.count);
    total++; if (busy600 !== 1'b1) begin bad++; $display("FAIL s5_busy600: got %0b want 1", busy600); end
    total++; if (busy601 !== 1'b0) begin bad++; $display("FAIL s5_busy601: got %0b want 0", busy601); end
    total++; if (vseen !== 0) begin bad++; $display("FAIL s5_no_valid: got %0d valid cycles want 0", vseen); end
    total++; if (busy_after !== 0) begin bad++; $display("FAIL s5_no_queue: got %0d busy cycles want 0", busy_after); end
    total++; if (if8.count !== 8'd255 || if8.overflow !== 1'b1) begin
      bad++; $display("FAIL s5_hold8: got %0d ovf %0b want 255 ovf 1", if8.count, if8.overflow);
    end
    total++; if (c16 < 340 || c16 > 342) begin bad++; $display("FAIL s5_hold16: got %0d want 340..342", c16); end
  endtask

  task automatic test_back_to_back;
    int lat, bc, vc, c16, idle_busy;
    ring_half = 40;
    run_meas(2'd0, 500, lat, bc, vc);
    c16 = int'(if16.count);
    total++; if (lat !== 1026 || bc !== 1026) begin bad++; $display("FAIL b2b_busy_start: lat %0d busy %0d want 1026 1026", lat, bc); end
    total++; if (c16 < 127 || c16 > 129) begin bad++; $display("FAIL b2b_count: got %0d want 127..129", c16); end
    run_meas(2'd0, 1026, lat, bc, vc);
    total++; if (bc !== 1026 || vc !== 1) begin bad++; $display("FAIL b2b_done_start: busy %0d valid %0d want 1026 1", bc, vc); end
    idle_busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (if16.busy) idle_busy++;
    end
    total++; if (idle_busy !== 0) begin bad++; $display("FAIL b2b_idle_after: got %0d busy cycles want 0", idle_busy); end
  endtask

  task automatic test_reset_mid;
    int lat, bc, vc, c16, seen;
    ring_half = 40;
    @(negedge clk);
    win_sel = 2'd0;
    ena     = 1'b1;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (300) @(negedge clk);
    total++; if (if16.busy !== 1'b1) begin bad++; $display("FAIL s6_busy_before: got %0b want 1", if16.busy); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (if16.count !== 16'd0) begin bad++; $display("FAIL s6_count: got %0d want 0", if16.count); end
    total++; if (if16.busy !== 1'b0 || if16.valid !== 1'b0) begin
      bad++; $display("FAIL s6_busy_valid: got %0b %0b want 0 0", if16.busy, if16.valid);
    end
    total++; if (if16.overflow !== 1'b0) begin bad++; $display("FAIL s6_overflow: got %0b want 0", if16.overflow); end
    total++; if (if8.count !== 8'd0 || if8.overflow !== 1'b0) begin
      bad++; $display("FAIL s6_out8: got %0d ovf %0b want 0 0", if8.count, if8.overflow);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    repeat (1200) begin
      @(negedge clk);
      if (if16.valid || if16.busy) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL s6_after_release: got %0d active cycles want 0", seen); end
    run_meas(2'd0, -1, lat, bc, vc);
    c16 = int'(if16.count);
    total++; if (c16 < 127 || c16 > 129 || lat !== 1026) begin
      bad++; $display("FAIL s6_rerun: count %0d lat %0d want 127..129 1026 (busy %0d valid %0d)", c16, lat, bc, vc);
    end
  endtask

  initial begin
    test_reset();
    test_no_spurious();
    test_win1024();
    test_win8192();
    test_saturate();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
